fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage of the 5-stage RV32I pipeline: owns the PC and issues in-order requests to a
//  valid/ready instruction memory. Buffers returned words with their PCs and drives the
//  IF/ID register consumed by the decode stage. Honours the pipeline stall and branch/jump
//  redirects; injects NOPs as bubbles.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC of first fetch after reset
//  BUF_DEPTH   4              instruction buffer entries = max in-flight+buffered words (>=2)
// PORTS
//  clk               in   1   clock, rising edge
//  rst               in   1   reset, asynchronous, active-high
//  stall             in   1   hazard unit: hold IF/ID register
//  redirect_valid    in   1   taken branch/jump from EX
//  redirect_pc       in   32  redirect target
//  imem_req_valid    out  1   fetch request valid
//  imem_req_ready    in   1   memory accepts request
//  imem_req_addr     out  32  word address of request (bits[1:0]=0)
//  imem_rsp_valid    in   1   response valid (in order, no backpressure, latency>=1)
//  imem_rsp_data     in   32  instruction word
//  if_id_instr_data  out  32  instruction to decode
//  if_id_pc          out  32  PC of if_id_instr_data
// BEHAVIOUR
//  Reset (async): fetch_pc=RESET_PC, in-flight cnt=0, drop cnt=0, buffer empty,
//   if_id_instr_data=NOP (32'h0000_0013), if_id_pc=0; imem_req_valid=0 while rst high.
//  Request: imem_req_valid = (inflight_cnt + buf_cnt < BUF_DEPTH) && !redirect_valid;
//   counts are registered values. imem_req_addr=fetch_pc. On accept: fetch_pc+=4
//   (wraps mod 2^32), PC pushed to in-flight PC queue, inflight_cnt++.
//   req_valid held, addr stable until accepted (unless redirect).
//  Response: pops in-flight PC queue, inflight_cnt--. If drop_cnt>0: word discarded,
//   drop_cnt--. Else {pc,data} pushed to buffer. Credit rule guarantees no overflow.
//  IF/ID update, priority redirect > stall > normal:
//   redirect_valid: if_id <= {NOP,pc 0}; buffer flushed; fetch_pc <= {redirect_pc[31:2],2'b00};
//    drop_cnt <= inflight_cnt - (rsp_valid this cycle); no request issued this cycle.
//   stall (no redirect): if_id holds; requests/responses continue normally.
//   else: buffer non-empty -> if_id <= head, pop; empty -> if_id <= {NOP,0}.
//  Latency: response word reaches if_id one edge after buffer write (no bypass); with
//   1-cycle memory, req accept at edge N -> if_id valid after edge N+2.
//  Throughput: BUF_DEPTH=4 with 1-cycle memory sustains one instruction per cycle.
//  Simultaneous buffer push+pop allowed; push+flush in redirect cycle: flush wins,
//   response counted as dropped-now. Redirect while drop_cnt>0 adds new in-flight to it.
//  Reset mid-operation: all state cleared immediately; responses to pre-reset requests
//   are the memory model's responsibility to suppress (memory reset together).
// STRUCTURE
//  instruction_utils package: add NOP_ENCODING = 32'h0000_0013 (shared with decode bubbles).
//  Sub-module fetch_fifo #(WIDTH,DEPTH): sync FIFO, push/pop/flush, count, async reset;
//   instantiated twice: in-flight PC queue (WIDTH 32), instruction buffer (WIDTH 64).
//  fetch_stage holds fetch_pc, drop_cnt, IF/ID register, credit logic.
// TESTING
//  1 rst pulse mid-stream -> if_id=NOP/0, req_valid=0; after release first addr=RESET_PC.
//  2 1-cycle mem, always ready, data=addr -> after warm-up if_id_pc 0,4,8.. one per cycle,
//    instr==pc.
//  3 stall 3 cycles at if_id_pc=0x10 -> if_id holds 0x10; req_valid drops at 4 credits;
//    release -> 0x14,0x18 back-to-back.
//  4 redirect_pc=0x100 with 2 in flight -> if_id NOP next edge, 2 stale rsps dropped, next
//    req addr 0x100, next non-NOP if_id_pc=0x100.
//  5 redirect+stall same cycle, redirect_pc=0x203 -> if_id NOP, next req addr 0x200.
//  6 imem_req_ready low 5 cycles -> req_addr stable, if_id drains buffer then NOPs.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-side definitions: the canonical NOP used for pipeline bubbles (also used by
// decode), the buffered instruction entry layout, and the IF/ID update actions.
package fetch_stage_pkg;

   localparam int          XLEN         = 32;
   localparam logic [31:0] NOP_ENCODING = 32'h0000_0013;
   localparam logic [31:0] PC_STEP      = 32'd4;
   localparam logic [31:0] WORD_MASK    = 32'hFFFF_FFFC;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      IFID_FLUSH,
      IFID_HOLD,
      IFID_LOAD,
      IFID_BUBBLE
   } ifid_action_e;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return addr & WORD_MASK;
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Valid/ready instruction memory port: in-order responses, no response backpressure.
interface fetch_stage_if;
   import fetch_stage_pkg::*;

   logic            req_valid;
   logic            req_ready;
   logic [XLEN-1:0] req_addr;
   logic            rsp_valid;
   logic [XLEN-1:0] rsp_data;

   modport master (
      output req_valid,
      output req_addr,
      input  req_ready,
      input  rsp_valid,
      input  rsp_data
   );

   modport slave (
      input  req_valid,
      input  req_addr,
      output req_ready,
      output rsp_valid,
      output rsp_data
   );

endinterface

// File: rtl/fetch_stage_fifo.sv
// Small synchronous FIFO with flush; used for the in-flight PC queue and the fetched
// instruction buffer. Flush overrides any push or pop in the same cycle.
module fetch_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         flush,
   input  logic [WIDTH-1:0]             push_data,
   output logic [WIDTH-1:0]             head_data,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty     = (count == '0);
   assign full      = (count == CNT_W'(DEPTH));
   assign do_pop    = pop && !empty;
   assign do_push   = push && (!full || do_pop);
   assign head_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= next_ptr(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         if (do_push && !do_pop) begin
            count <= count + CNT_W'(1);
         end else if (do_pop && !do_push) begin
            count <= count - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// RV32I IF stage: owns the fetch PC, issues credit-limited in-order memory requests,
// buffers returned words with their PCs and drives the IF/ID register.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               redirect_valid,
   input  logic [XLEN-1:0]    redirect_pc,
   fetch_stage_if.master      imem,
   output logic [XLEN-1:0]    if_id_instr_data,
   output logic [XLEN-1:0]    if_id_pc
);

   localparam int CNT_W = $clog2(BUF_DEPTH + 1);

   logic [XLEN-1:0]  fetch_pc;
   logic [CNT_W-1:0] drop_cnt;
   logic [CNT_W-1:0] inflight_cnt;
   logic [CNT_W-1:0] buf_cnt;
   logic             inflight_empty;
   logic [XLEN-1:0]  inflight_head_pc;
   logic             buf_empty;
   fetch_entry_t     buf_head;
   fetch_entry_t     rsp_entry;

   logic             credit_ok;
   logic             req_fire;
   logic             rsp_fire;
   logic             drop_active;
   logic             buf_push;
   logic             buf_pop;

   ifid_action_e     ifid_action;
   logic [XLEN-1:0]  ifid_instr_next;
   logic [XLEN-1:0]  ifid_pc_next;

   // A request is only issued while every possible returning word has a buffer slot,
   // so the buffer can never overflow even though responses cannot be stalled.
   assign credit_ok     = ({1'b0, inflight_cnt} + {1'b0, buf_cnt}) < (CNT_W + 1)'(BUF_DEPTH);
   assign imem.req_valid = !rst && credit_ok && !redirect_valid;
   assign imem.req_addr  = fetch_pc;
   assign req_fire       = imem.req_valid && imem.req_ready;

   assign rsp_fire    = imem.rsp_valid && !inflight_empty;
   assign drop_active = (drop_cnt != '0);
   assign buf_push    = rsp_fire && !drop_active && !redirect_valid;
   assign buf_pop     = !redirect_valid && !stall && !buf_empty;

   assign rsp_entry.pc    = inflight_head_pc;
   assign rsp_entry.instr = imem.rsp_data;

   fetch_fifo #(
      .WIDTH (XLEN),
      .DEPTH (BUF_DEPTH)
   ) u_inflight_q (
      .clk       (clk),
      .rst       (rst),
      .push      (req_fire),
      .pop       (rsp_fire),
      .flush     (1'b0),
      .push_data (fetch_pc),
      .head_data (inflight_head_pc),
      .count     (inflight_cnt),
      .empty     (inflight_empty)
   );

   fetch_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (BUF_DEPTH)
   ) u_instr_buf (
      .clk       (clk),
      .rst       (rst),
      .push      (buf_push),
      .pop       (buf_pop),
      .flush     (redirect_valid),
      .push_data (rsp_entry),
      .head_data (buf_head),
      .count     (buf_cnt),
      .empty     (buf_empty)
   );

   // Everything still in flight at a redirect belongs to the old path, including any
   // words already marked for dropping, minus the one that returns this very cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         drop_cnt <= '0;
      end else if (redirect_valid) begin
         fetch_pc <= word_align(redirect_pc);
         drop_cnt <= inflight_cnt - CNT_W'(rsp_fire);
      end else begin
         if (req_fire) begin
            fetch_pc <= fetch_pc + PC_STEP;
         end
         if (rsp_fire && drop_active) begin
            drop_cnt <= drop_cnt - CNT_W'(1);
         end
      end
   end

   // Redirect beats stall; an unstalled stage with nothing buffered emits a bubble.
   always_comb begin
      ifid_action     = IFID_BUBBLE;
      ifid_instr_next = NOP_ENCODING;
      ifid_pc_next    = '0;
      if (redirect_valid) begin
         ifid_action = IFID_FLUSH;
      end else if (stall) begin
         ifid_action = IFID_HOLD;
      end else if (!buf_empty) begin
         ifid_action = IFID_LOAD;
      end
      case (ifid_action)
         IFID_HOLD: begin
            ifid_instr_next = if_id_instr_data;
            ifid_pc_next    = if_id_pc;
         end
         IFID_LOAD: begin
            ifid_instr_next = buf_head.instr;
            ifid_pc_next    = buf_head.pc;
         end
         default: begin
            ifid_instr_next = NOP_ENCODING;
            ifid_pc_next    = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if_id_instr_data <= NOP_ENCODING;
         if_id_pc         <= '0;
      end else begin
         if_id_instr_data <= ifid_instr_next;
         if_id_pc         <= ifid_pc_next;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios plus randomized traffic against a
// program-order model of the expected fetch address and IF/ID instruction stream.
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam int          BUF_DEPTH = 4;
   localparam logic [31:0] DATA_KEY  = 32'h5A00_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] if_id_instr_data;
   logic [31:0] if_id_pc;

   fetch_stage_if imem_bus ();

   fetch_stage #(
      .RESET_PC  (RESET_PC),
      .BUF_DEPTH (BUF_DEPTH)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .stall            (stall),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .imem             (imem_bus),
      .if_id_instr_data (if_id_instr_data),
      .if_id_pc         (if_id_pc)
   );

   always #5 clk = ~clk;

   int          tests_run    = 0;
   int          tests_failed = 0;
   int          cyc          = 0;
   int          mem_lat_min  = 1;
   int          mem_lat_max  = 1;
   int          outstanding  = 0;
   int          bubbles      = 0;
   logic [31:0] mem_addr_q[$];
   int          mem_due_q[$];
   logic [31:0] exp_pc;
   logic [31:0] exp_req_addr;
   logic [31:0] last_instr;
   logic [31:0] last_pc;
   logic [31:0] s_addr;
   logic        s_reqv;
   logic        prev_wait    = 1'b0;
   logic        saw_low;

   // Memory contents are a function of the address, never equal to the NOP encoding.
   function automatic logic [31:0] memWord(input logic [31:0] addr);
      return addr ^ DATA_KEY;
   endfunction

   function automatic logic isBubble();
      return (if_id_instr_data == NOP_ENCODING) && (if_id_pc == 32'h0);
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", tag, actual, expected, cyc);
      end
   endtask

   // One clock cycle: drive memory response and control inputs, sample the request,
   // then after the edge advance the program-order model and check IF/ID.
   task automatic applyStimulus(input logic st, input logic rd, input logic [31:0] tgt, input logic rdy);
      logic        acc;
      logic        rsp;
      logic [31:0] rsp_addr;
      rsp      = 1'b0;
      rsp_addr = 32'h0;
      if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
         rsp      = 1'b1;
         rsp_addr = mem_addr_q.pop_front();
         void'(mem_due_q.pop_front());
      end
      imem_bus.rsp_valid = rsp;
      imem_bus.rsp_data  = rsp ? memWord(rsp_addr) : $urandom;
      imem_bus.req_ready = rdy;
      stall              = st;
      redirect_valid     = rd;
      redirect_pc        = tgt;
      #1;
      s_reqv = imem_bus.req_valid;
      s_addr = imem_bus.req_addr;
      if (prev_wait && !rd) checkOutput("req_held", {63'h0, s_reqv}, 64'h1);
      if (s_reqv) checkOutput("req_addr", {32'h0, s_addr}, {32'h0, exp_req_addr});
      acc       = s_reqv && rdy;
      prev_wait = s_reqv && !rdy;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
         mem_addr_q.push_back(s_addr);
         mem_due_q.push_back(cyc + $urandom_range(mem_lat_min, mem_lat_max) - 1);
         exp_req_addr = exp_req_addr + 32'd4;
         outstanding++;
      end
      if (rsp) outstanding--;
      if (rd) exp_req_addr = tgt & 32'hFFFF_FFFC;
      checkOutput("outstanding_limit", {63'h0, outstanding <= BUF_DEPTH}, 64'h1);
      if (rd) begin
         checkOutput("redirect_nop_instr", {32'h0, if_id_instr_data}, {32'h0, NOP_ENCODING});
         checkOutput("redirect_nop_pc", {32'h0, if_id_pc}, 64'h0);
         exp_pc = tgt & 32'hFFFF_FFFC;
      end else if (st) begin
         checkOutput("stall_hold_instr", {32'h0, if_id_instr_data}, {32'h0, last_instr});
         checkOutput("stall_hold_pc", {32'h0, if_id_pc}, {32'h0, last_pc});
      end else if (!isBubble()) begin
         checkOutput("stream_pc", {32'h0, if_id_pc}, {32'h0, exp_pc});
         checkOutput("stream_instr", {32'h0, if_id_instr_data}, {32'h0, memWord(exp_pc)});
         exp_pc = exp_pc + 32'd4;
      end else begin
         bubbles++;
      end
      last_instr = if_id_instr_data;
      last_pc    = if_id_pc;
   endtask

   // Asynchronous reset pulse in mid-cycle; the memory model is reset alongside.
   task automatic applyReset();
      #3;
      rst = 1'b1;
      #1;
      checkOutput("reset_instr", {32'h0, if_id_instr_data}, {32'h0, NOP_ENCODING});
      checkOutput("reset_pc", {32'h0, if_id_pc}, 64'h0);
      checkOutput("reset_req_valid", {63'h0, imem_bus.req_valid}, 64'h0);
      mem_addr_q.delete();
      mem_due_q.delete();
      outstanding        = 0;
      exp_pc             = RESET_PC;
      exp_req_addr       = RESET_PC;
      last_instr         = NOP_ENCODING;
      last_pc            = 32'h0;
      prev_wait          = 1'b0;
      imem_bus.rsp_valid = 1'b0;
      imem_bus.req_ready = 1'b1;
      stall              = 1'b0;
      redirect_valid     = 1'b0;
      @(posedge clk);
      #4;
      cyc++;
      rst = 1'b0;
      #1;
      checkOutput("reset_first_valid", {63'h0, imem_bus.req_valid}, 64'h1);
      checkOutput("reset_first_addr", {32'h0, imem_bus.req_addr}, {32'h0, RESET_PC});
   endtask

   initial begin
      rst                = 1'b0;
      stall              = 1'b0;
      redirect_valid     = 1'b0;
      redirect_pc        = 32'h0;
      imem_bus.req_ready = 1'b1;
      imem_bus.rsp_valid = 1'b0;
      imem_bus.rsp_data  = 32'h0;
      exp_pc             = RESET_PC;
      exp_req_addr       = RESET_PC;
      last_instr         = NOP_ENCODING;
      last_pc            = 32'h0;
      applyReset();

      // Sustained one-per-cycle delivery with a 1-cycle, always-ready memory.
      repeat (4) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      bubbles = 0;
      repeat (12) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("throughput_bubbles", bubbles, 64'h0);

      // Stall holding IF/ID at 0x10 until credits run out.
      applyReset();
      for (int i = 0; i < 20 && !(if_id_pc == 32'h10 && !isBubble()); i++)
         applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("stall_reach_pc", {32'h0, if_id_pc}, 64'h10);
      saw_low = 1'b0;
      repeat (3) begin
         applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
         if (!s_reqv) saw_low = 1'b1;
      end
      checkOutput("stall_credit_drop", {63'h0, saw_low}, 64'h1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("stall_release_pc0", {32'h0, if_id_pc}, 64'h14);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("stall_release_pc1", {32'h0, if_id_pc}, 64'h18);

      // Redirect with two requests in flight.
      mem_lat_min = 2;
      mem_lat_max = 2;
      repeat (8) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 10 && outstanding < 2; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("redirect_inflight", {63'h0, outstanding >= 2}, 64'h1);
      applyStimulus(1'b0, 1'b1, 32'h100, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("redirect_next_valid", {63'h0, s_reqv}, 64'h1);
      checkOutput("redirect_next_addr", {32'h0, s_addr}, 64'h100);
      for (int i = 0; i < 20 && isBubble(); i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("redirect_first_pc", {32'h0, if_id_pc}, 64'h100);

      // Redirect and stall together to an unaligned target.
      mem_lat_min = 1;
      mem_lat_max = 1;
      repeat (6) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      applyStimulus(1'b1, 1'b1, 32'h203, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("redirect_stall_valid", {63'h0, s_reqv}, 64'h1);
      checkOutput("redirect_stall_addr", {32'h0, s_addr}, 64'h200);
      for (int i = 0; i < 20 && isBubble(); i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("redirect_stall_first_pc", {32'h0, if_id_pc}, 64'h200);

      // Memory not ready: address held, buffer drains into bubbles.
      repeat (6) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      repeat (5) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("ready_low_drained", {63'h0, isBubble()}, 64'h1);
      repeat (6) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

      // Reset mid-stream, then randomized traffic.
      applyReset();
      mem_lat_min = 1;
      mem_lat_max = 3;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            applyReset();
         end else begin
            applyStimulus($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 5,
                          $urandom, $urandom_range(0, 99) < 75);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
